// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter.
// Bytes are popped one at a time and launched with a one-cycle tx_start pulse.
// The block then waits for tx_done and adds one guard cycle before the next launch.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              tx_done,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = (state_q != IDLE);

  // FIFO bookkeeping: flush wins over both push and pop, and a push into a full FIFO is dropped.
  always_comb begin
    do_push    = wr_en && !full && !flush;
    do_pop     = (state_q == IDLE) && !empty && !flush;
    overflow_d = wr_en && full && !flush;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  // Launch sequencer: pop and pulse tx_start, wait for tx_done, then one guard cycle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    case (state_q)
      IDLE: begin
        if (do_pop) begin
          tx_start_d = 1'b1;
          tx_byte_d  = mem_q[rd_ptr_q];
          state_d    = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = GAP;
      GAP:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Byte storage needs no reset; stale contents are never read because count gates pops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers, cleared immediately by the shared transmitter reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

endmodule
